nibble_serial_adder: RTL and testbench

//   Sequencer that sits directly around the 4-bit fulladder stage. It feeds that

---
 rtl/nibble_serial_adder.sv | 151 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial sequencer around an external 4-bit full-adder stage
//
// Purpose:
//   Adds two WIDTH-bit unsigned operands one nibble per cycle through an
//   external combinational 4-bit adder. The carry is chained in a register.
//   Operands are accepted on a valid/ready handshake and the result is
//   presented on another valid/ready handshake. An op takes WIDTH/4 RUN
//   cycles, followed by one DONE cycle at minimum.
//
// Configuration:
//   NSA_SIGNED_OVF_EN - when defined, adds the result_ovf port. It reports
//                       two's-complement overflow of the full-width sum.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready high only in IDLE)
//   op_a, op_b, op_cin    operands and carry-in, latched on acceptance
//   add_a/add_b/add_cin   nibble operands to the adder stage (0 outside RUN)
//   add_sum/add_carry     combinational response of the adder stage
//   out_valid/out_ready   result handshake (out_valid high only in DONE)
//   result, result_carry  registered sum and MS-nibble carry-out
//   result_ovf            signed overflow flag (NSA_SIGNED_OVF_EN only)
//   busy                  high in RUN or DONE

module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_sum,
   input  logic             add_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             result_carry,
`ifdef NSA_SIGNED_OVF_EN
   output logic             result_ovf,
`endif
   output logic             busy
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IW      = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                    state;
   logic [IW-1:0]             idx;
   logic                      carry_reg;
   // Operands and result are held as nibble arrays so the active nibble
   // is selected by idx directly.
   logic [NIBBLES-1:0][3:0]   opa_reg;
   logic [NIBBLES-1:0][3:0]   opb_reg;
   logic [NIBBLES-1:0][3:0]   res_reg;
   logic                      res_carry_reg;
`ifdef NSA_SIGNED_OVF_EN
   logic                      ovf_reg;
`endif

   // The handshake and status outputs are plain decodes of the state register.
   assign in_ready     = (state == IDLE);
   assign out_valid    = (state == DONE);
   assign busy         = (state != IDLE);
   assign result       = res_reg;
   assign result_carry = res_carry_reg;
`ifdef NSA_SIGNED_OVF_EN
   assign result_ovf   = ovf_reg;
`endif

   // The adder-stage inputs are driven only from registers, so the external
   // adder sees a clean path starting at the flops.
   always_comb begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = opa_reg[idx];
         add_b   = opb_reg[idx];
         add_cin = carry_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         carry_reg     <= 1'b0;
         opa_reg       <= '0;
         opb_reg       <= '0;
         res_reg       <= '0;
         res_carry_reg <= 1'b0;
`ifdef NSA_SIGNED_OVF_EN
         ovf_reg       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opa_reg   <= op_a;
                  opb_reg   <= op_b;
                  carry_reg <= op_cin;
                  idx       <= '0;
                  res_reg   <= '0;
`ifdef NSA_SIGNED_OVF_EN
                  ovf_reg   <= 1'b0;
`endif
                  state     <= RUN;
               end
            end
            RUN: begin
               res_reg[idx] <= add_sum;
               carry_reg    <= add_carry;
               if (idx == LAST_IDX) begin
                  // The last nibble's carry and sum MSB form the final flags.
                  idx           <= '0;
                  res_carry_reg <= add_carry;
`ifdef NSA_SIGNED_OVF_EN
                  ovf_reg <= (opa_reg[NIBBLES-1][3] == opb_reg[NIBBLES-1][3]) &&
                             (add_sum[3] != opa_reg[NIBBLES-1][3]);
`endif
                  state         <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               // This state always returns to IDLE. A new op cannot be
               // accepted in the same cycle that the result leaves.
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder

module tb_nibble_serial_adder;

   localparam int WIDTH   = 16;
   localparam int NIBBLES = WIDTH / 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  op_a = '0;
   logic [WIDTH-1:0]  op_b = '0;
   logic              op_cin = 1'b0;
   logic [3:0]        add_a;
   logic [3:0]        add_b;
   logic              add_cin;
   logic [3:0]        add_sum;
   logic              add_carry;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [WIDTH-1:0]  result;
   logic              result_carry;
   logic              busy;
`ifdef NSA_SIGNED_OVF_EN
   logic              result_ovf;
`endif

   // Behavioural 4-bit full-adder stage on the add_* ports
   logic [4:0] fa;
   assign fa        = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
   assign add_sum   = fa[3:0];
   assign add_carry = fa[4];

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .op_cin       (op_cin),
      .add_a        (add_a),
      .add_b        (add_b),
      .add_cin      (add_cin),
      .add_sum      (add_sum),
      .add_carry    (add_carry),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .result_carry (result_carry),
`ifdef NSA_SIGNED_OVF_EN
      .result_ovf   (result_ovf),
`endif
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] res;
      logic        carry;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic        carry;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: every result handshake pops one expected record.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: result %h with no op pending", result);
         end else begin
            mon_e = sb.pop_front();
            check("result", {16'h0, result}, {16'h0, mon_e.res});
            check("result_carry", {31'h0, result_carry}, {31'h0, mon_e.carry});
`ifdef NSA_SIGNED_OVF_EN
            check("result_ovf", {31'h0, result_ovf}, {31'h0, mon_e.ovf});
`endif
         end
      end
   end

   // Issues one op and returns once out_valid is seen (or the bound expires).
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] eres, input logic ecarry,
                        input bit hold, output int lat, output logic cin0, output logic [3:0] a0);
      int   guard;
      exp_t e;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("in_ready_before_op", {31'h0, in_ready}, 32'h1);
      out_ready = !hold;
      op_a      = a;
      op_b      = b;
      op_cin    = cin;
      in_valid  = 1'b1;
      e.res   = eres;
      e.carry = ecarry;
      e.ovf   = (a[15] == b[15]) && (eres[15] != a[15]);
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Scramble the operand inputs after acceptance; the latched copy must be used.
      op_a   = 16'($urandom);
      op_b   = 16'($urandom);
      op_cin = 1'($urandom);
      cin0   = add_cin;
      a0     = add_a;
      lat    = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, NIBBLES);
   endtask

   initial begin
      vec_t        vt[6];
      int          lat;
      logic        c0;
      logic [3:0]  a0;
      logic [15:0] ra, rb;
      logic        rc;
      logic [16:0] s;

      vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
      vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vt[2] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0};
      vt[3] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
      vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_result", {16'h0, result}, 32'h0);
      check("rst_result_carry", {31'h0, result_carry}, 32'h0);
      check("rst_add_cin", {31'h0, add_cin}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         do_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].res, vt[i].carry, 1'b0, lat, c0, a0);
         check("busy_in_done", {31'h0, busy}, 32'h1);
         if (i == 2) begin
            check("add_cin_first_run", {31'h0, c0}, 32'h1);
            check("add_a_first_run", {28'h0, a0}, 32'hF);
         end
         @(posedge clk); #1;
      end

      // Random ops, expected sum computed by the bench
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         s  = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
         do_op(ra, rb, rc, s[15:0], s[16], 1'b0, lat, c0, a0);
         check("rand_add_a_first_run", {28'h0, a0}, {28'h0, ra[3:0]});
         @(posedge clk); #1;
      end

      // Backpressure: result holds, in_valid ignored
      do_op(16'hA5A5, 16'h0F0F, 1'b0, 16'hB4B4, 1'b0, 1'b1, lat, c0, a0);
      for (int i = 0; i < 5; i++) begin
         check("hold_out_valid", {31'h0, out_valid}, 32'h1);
         check("hold_in_ready", {31'h0, in_ready}, 32'h0);
         check("hold_result", {16'h0, result}, 32'h0000B4B4);
         if (i == 1) begin
            in_valid = 1'b1;
            op_a     = 16'h1111;
            op_b     = 16'h1111;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      check("hold_result_after", {16'h0, result}, 32'h0000B4B4);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_in_ready", {31'h0, in_ready}, 32'h1);
      check("release_out_valid", {31'h0, out_valid}, 32'h0);
      check("release_busy", {31'h0, busy}, 32'h0);

      // Reset during the second RUN cycle aborts the op
      op_a     = 16'h1111;
      op_b     = 16'h2222;
      op_cin   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("midrun_busy", {31'h0, busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", {31'h0, in_ready}, 32'h1);
      check("abort_out_valid", {31'h0, out_valid}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_result", {16'h0, result}, 32'h0);
      check("abort_result_carry", {31'h0, result_carry}, 32'h0);
      check("abort_add_a", {28'h0, add_a}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, lat, c0, a0);
      @(posedge clk); #1;

`ifdef NSA_SIGNED_OVF_EN
      do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, lat, c0, a0);
      check("ovf_set", {31'h0, result_ovf}, 32'h1);
      @(posedge clk); #1;
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, lat, c0, a0);
      check("ovf_clear", {31'h0, result_ovf}, 32'h0);
      @(posedge clk); #1;
`endif

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
